lynx_video_shifter: RTL and testbench

- Downstream of the UM6845R CRTC in the Lynx video path.
- Generates the CRTC character clock enable and latches MA/RA/DE/CURSOR at each character boundary.
- Fetches the three colour-plane bytes (R, B, G) for that character from a shared byte-wide VRAM port, then serialises them MSB-first as 1-bit RGB pixels.
- Delays HSYNC/VSYNC/DE by exactly one character so they stay aligned with the pixels.

---
 rtl/lynx_video_shifter.sv | 179 +++++++++++++++++
 tb/tb_lynx_video_shifter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lynx_video_shifter.sv
// Lynx video shifter: makes the CRTC character clock enable, fetches the R/B/G plane bytes
// for each character and shifts them out MSB-first, with timing delayed one character.
module lynx_video_shifter #(
  parameter bit INVERT_CURSOR = 1'b1
) (
  input  logic        CLOCK,
  input  logic        nRESET,
  input  logic        PIXEN,
  output logic        CHAR_CE,
  input  logic [13:0] MA,
  input  logic [4:0]  RA,
  input  logic        DE_IN,
  input  logic        HS_IN,
  input  logic        VS_IN,
  input  logic        CURSOR,
  output logic [12:0] VA,
  output logic [1:0]  VPLANE,
  output logic        VRD,
  input  logic [7:0]  VDI,
  output logic        R,
  output logic        G,
  output logic        B,
  output logic        DE,
  output logic        HSYNC,
  output logic        VSYNC
);

  localparam int unsigned PH_W   = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned VA_W   = 13;
  localparam int unsigned PL_W   = 2;

  localparam logic [PH_W-1:0] PH_CAPTURE = PH_W'(0);
  localparam logic [PH_W-1:0] PH_FETCH0  = PH_W'(1);
  localparam logic [PH_W-1:0] PH_FETCH2  = PH_W'(3);
  localparam logic [PH_W-1:0] PH_LOAD    = PH_W'(7);

  localparam logic [PL_W-1:0] PL_R = PL_W'(0);
  localparam logic [PL_W-1:0] PL_B = PL_W'(1);
  localparam logic [PL_W-1:0] PL_G = PL_W'(2);

  logic [PH_W-1:0]   r_phase;
  logic              r_char_ce;

  logic              r_cap_de;
  logic              r_cap_hs;
  logic              r_cap_vs;
  logic              r_cap_cur;
  logic [VA_W-1:0]   r_va;

  logic              r_vrd;
  logic [PL_W-1:0]   r_vplane;

  logic [BYTE_W-1:0] r_stage_r;
  logic [BYTE_W-1:0] r_stage_b;
  logic [BYTE_W-1:0] r_stage_g;

  logic [BYTE_W-1:0] r_shift_r;
  logic [BYTE_W-1:0] r_shift_b;
  logic [BYTE_W-1:0] r_shift_g;
  logic              r_de;
  logic              r_hs;
  logic              r_vs;

  logic              w_capture;
  logic              w_fetch;
  logic              w_load;
  logic [PL_W-1:0]   w_fetch_plane;
  logic [BYTE_W-1:0] w_inv_mask;
  logic              w_unused_addr_bits;

  // Per-pixel event decode from the character phase
  assign w_capture     = PIXEN && (r_phase == PH_CAPTURE);
  assign w_fetch       = PIXEN && (r_phase >= PH_FETCH0) && (r_phase <= PH_FETCH2);
  assign w_load        = PIXEN && (r_phase == PH_LOAD);
  assign w_fetch_plane = PL_W'(r_phase - PH_FETCH0);
  assign w_inv_mask    = (INVERT_CURSOR && r_cap_cur) ? {BYTE_W{1'b1}} : {BYTE_W{1'b0}};

  // Upper MA/RA bits do not address the 8 KB plane
  assign w_unused_addr_bits = ^{MA[13:10], RA[4:3]};

  // Character phase counter and CRTC clock enable
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      r_phase   <= '0;
      r_char_ce <= 1'b0;
    end else begin
      r_char_ce <= w_load;
      if (PIXEN) begin
        r_phase <= r_phase + PH_W'(1);
      end
    end
  end

  // CRTC outputs latched at the start of each character
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      r_cap_de  <= 1'b0;
      r_cap_hs  <= 1'b0;
      r_cap_vs  <= 1'b0;
      r_cap_cur <= 1'b0;
      r_va      <= '0;
    end else if (w_capture) begin
      r_cap_de  <= DE_IN;
      r_cap_hs  <= HS_IN;
      r_cap_vs  <= VS_IN;
      r_cap_cur <= CURSOR;
      r_va      <= {MA[9:0], RA[2:0]};
    end
  end

  // One read strobe per plane while the captured character is displayed
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      r_vrd    <= 1'b0;
      r_vplane <= PL_R;
    end else begin
      r_vrd <= w_fetch && r_cap_de;
      if (w_fetch && r_cap_de) begin
        r_vplane <= w_fetch_plane;
      end
    end
  end

  // Staging bytes; VDI is taken on the edge after a strobe regardless of PIXEN
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      r_stage_r <= '0;
      r_stage_b <= '0;
      r_stage_g <= '0;
    end else if (w_fetch && !r_cap_de) begin
      r_stage_r <= '0;
      r_stage_b <= '0;
      r_stage_g <= '0;
    end else if (r_vrd) begin
      case (r_vplane)
        PL_R:    r_stage_r <= VDI;
        PL_B:    r_stage_b <= VDI;
        PL_G:    r_stage_g <= VDI;
        default: ;
      endcase
    end
  end

  // Load at the character boundary, otherwise shift left one pixel per PIXEN
  always_ff @(posedge CLOCK) begin
    if (!nRESET) begin
      r_shift_r <= '0;
      r_shift_b <= '0;
      r_shift_g <= '0;
      r_de      <= 1'b0;
      r_hs      <= 1'b0;
      r_vs      <= 1'b0;
    end else if (w_load) begin
      r_shift_r <= r_stage_r ^ w_inv_mask;
      r_shift_b <= r_stage_b ^ w_inv_mask;
      r_shift_g <= r_stage_g ^ w_inv_mask;
      r_de      <= r_cap_de;
      r_hs      <= r_cap_hs;
      r_vs      <= r_cap_vs;
    end else if (PIXEN) begin
      r_shift_r <= {r_shift_r[BYTE_W-2:0], 1'b0};
      r_shift_b <= {r_shift_b[BYTE_W-2:0], 1'b0};
      r_shift_g <= {r_shift_g[BYTE_W-2:0], 1'b0};
    end
  end

  assign CHAR_CE = r_char_ce;
  assign VA      = r_va;
  assign VPLANE  = r_vplane;
  assign VRD     = r_vrd;
  assign R       = r_shift_r[BYTE_W-1];
  assign G       = r_shift_g[BYTE_W-1];
  assign B       = r_shift_b[BYTE_W-1];
  assign DE      = r_de;
  assign HSYNC   = r_hs;
  assign VSYNC   = r_vs;

endmodule

// File: tb/tb_lynx_video_shifter.sv
// Bench for lynx_video_shifter: directed character table plus randomized run checked
// against a pixel-index reference model with a synthetic VRAM.
module tb_lynx_video_shifter;

  localparam bit INV = 1'b1;

  logic        CLOCK = 1'b0;
  logic        nRESET;
  logic        PIXEN;
  logic        CHAR_CE;
  logic [13:0] MA;
  logic [4:0]  RA;
  logic        DE_IN, HS_IN, VS_IN, CURSOR;
  logic [12:0] VA;
  logic [1:0]  VPLANE;
  logic        VRD;
  logic [7:0]  VDI;
  logic        R, G, B, DE, HSYNC, VSYNC;

  // VRAM override for directed characters
  logic       ov_en;
  logic [7:0] ov_r, ov_b, ov_g;

  int checks = 0;
  int errors = 0;

  lynx_video_shifter #(.INVERT_CURSOR(INV)) dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .PIXEN(PIXEN), .CHAR_CE(CHAR_CE),
    .MA(MA), .RA(RA), .DE_IN(DE_IN), .HS_IN(HS_IN), .VS_IN(VS_IN), .CURSOR(CURSOR),
    .VA(VA), .VPLANE(VPLANE), .VRD(VRD), .VDI(VDI),
    .R(R), .G(G), .B(B), .DE(DE), .HSYNC(HSYNC), .VSYNC(VSYNC)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [7:0] vbyte(input logic [1:0] plane, input logic [12:0] a,
                                       input logic en, input logic [7:0] vr, vb, vg);
    logic [31:0] h;
    if (en && plane == 2'd0) return vr;
    if (en && plane == 2'd1) return vb;
    if (en && plane == 2'd2) return vg;
    h = 32'(a) * 32'd2654435761 + 32'(plane) * 32'd97;
    return h[23:16];
  endfunction

  // Data is only meaningful while the strobe is high; garbage otherwise
  assign VDI = VRD ? vbyte(VPLANE, VA, ov_en, ov_r, ov_b, ov_g)
                   : ~vbyte(VPLANE, VA, ov_en, ov_r, ov_b, ov_g);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model: everything indexed by PIXEN count ----------------
  typedef struct {
    logic        de, hs, vs, cur;
    logic [12:0] va;
    logic [7:0]  pr, pb, pg;
  } char_t;

  char_t chars[16];
  int    n = -1;
  bit    pix_last = 1'b0;
  bit    started = 1'b0;

  always @(posedge CLOCK) begin
    if (!nRESET) begin
      started  = 1'b1;
      n        = -1;
      pix_last = 1'b0;
    end else begin
      pix_last = PIXEN;
      if (PIXEN) begin
        n++;
        if (n % 8 == 0) begin
          char_t c;
          c.de  = DE_IN;
          c.hs  = HS_IN;
          c.vs  = VS_IN;
          c.cur = CURSOR;
          c.va  = {MA[9:0], RA[2:0]};
          c.pr  = DE_IN ? vbyte(2'd0, c.va, ov_en, ov_r, ov_b, ov_g) : 8'h00;
          c.pb  = DE_IN ? vbyte(2'd1, c.va, ov_en, ov_r, ov_b, ov_g) : 8'h00;
          c.pg  = DE_IN ? vbyte(2'd2, c.va, ov_en, ov_r, ov_b, ov_g) : 8'h00;
          chars[(n / 8) % 16] = c;
        end
      end
    end
  end

  // Outputs are a pure function of how many PIXENs have passed since reset
  always @(negedge CLOCK) begin
    if (started) begin
      logic       e_ce, e_vrd, e_r, e_g, e_b, e_de, e_hs, e_vs;
      logic [7:0] br, bb, bg, m;
      char_t      ch;
      int         j;
      e_ce  = pix_last && (n % 8 == 7);
      e_vrd = 1'b0;
      if (pix_last && n >= 0 && (n % 8) >= 1 && (n % 8) <= 3)
        e_vrd = chars[(n / 8) % 16].de;
      {e_r, e_g, e_b, e_de, e_hs, e_vs} = '0;
      if (n >= 7) begin
        ch = chars[((n - 7) / 8) % 16];
        j  = (n - 7) % 8;
        m  = (INV && ch.cur) ? 8'hFF : 8'h00;
        br = ch.pr ^ m;
        bb = ch.pb ^ m;
        bg = ch.pg ^ m;
        e_r  = br[7 - j];
        e_g  = bg[7 - j];
        e_b  = bb[7 - j];
        e_de = ch.de;
        e_hs = ch.hs;
        e_vs = ch.vs;
      end
      chk("mdl_charce", 32'(CHAR_CE), 32'(e_ce));
      chk("mdl_vrd", 32'(VRD), 32'(e_vrd));
      chk("mdl_rgb", 32'({R, G, B}), 32'({e_r, e_g, e_b}));
      chk("mdl_sync", 32'({DE, HSYNC, VSYNC}), 32'({e_de, e_hs, e_vs}));
      if (e_vrd) begin
        chk("mdl_va", 32'(VA), 32'(chars[(n / 8) % 16].va));
        chk("mdl_vplane", 32'(VPLANE), 32'((n % 8) - 1));
      end
    end
  end

  // ---------------- directed helpers ----------------
  int         pulse_no, first_ce, vrd_cnt, ce_cnt;
  logic [12:0] va_seen;
  logic [1:0]  pl_seen[3];
  logic        smp_r, smp_g, smp_b, smp_de, smp_hs;

  task automatic observe();
    if (VRD) begin
      if (vrd_cnt < 3) pl_seen[vrd_cnt] = VPLANE;
      vrd_cnt++;
      va_seen = VA;
    end
    if (CHAR_CE) begin
      ce_cnt++;
      if (first_ce == 0) first_ce = pulse_no;
    end
  endtask

  task automatic pulse(input int gap);
    @(negedge CLOCK);
    PIXEN = 1'b1;
    @(negedge CLOCK);
    PIXEN = 1'b0;
    pulse_no++;
    observe();
    {smp_r, smp_g, smp_b, smp_de, smp_hs} = {R, G, B, DE, HSYNC};
    for (int k = 1; k < gap; k++) begin
      @(negedge CLOCK);
      observe();
    end
  endtask

  typedef struct {
    logic [13:0] ma;
    logic [4:0]  ra;
    logic        de, hs, cur;
    logic [7:0]  vr, vb, vg;
    int          e_nvrd;
    logic [12:0] e_va;
    logic [7:0]  e_r, e_b, e_g;
    logic        e_de, e_hs;
  } vec_t;

  localparam int NV = 7;
  vec_t tbl[NV];

  initial begin
    logic [7:0] acc_r, acc_g, acc_b;

    tbl[0] = '{14'h0123, 5'd5,  1, 0, 0, 8'hA5, 8'hFF, 8'h00, 3, 13'h091D, 8'hA5, 8'hFF, 8'h00, 1, 0};
    tbl[1] = '{14'h0000, 5'd0,  0, 0, 0, 8'h5A, 8'h5A, 8'h5A, 0, 13'h0000, 8'h00, 8'h00, 8'h00, 0, 0};
    tbl[2] = '{14'h3FFF, 5'd31, 1, 0, 1, 8'hF0, 8'h00, 8'h0F, 3, 13'h1FFF, 8'h0F, 8'hFF, 8'hF0, 1, 0};
    tbl[3] = '{14'h0400, 5'd8,  1, 1, 0, 8'h3C, 8'hC3, 8'h81, 3, 13'h0000, 8'h3C, 8'hC3, 8'h81, 1, 1};
    tbl[4] = '{14'h0055, 5'd2,  1, 1, 0, 8'h01, 8'h80, 8'h7E, 3, 13'h02AA, 8'h01, 8'h80, 8'h7E, 1, 1};
    tbl[5] = '{14'h0001, 5'd7,  1, 0, 0, 8'hFF, 8'h00, 8'h55, 3, 13'h000F, 8'hFF, 8'h00, 8'h55, 1, 0};
    tbl[6] = '{14'h0000, 5'd0,  0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 13'h0000, 8'h00, 8'h00, 8'h00, 0, 0};

    nRESET = 1'b0; PIXEN = 1'b0;
    MA = '0; RA = '0; DE_IN = 0; HS_IN = 0; VS_IN = 0; CURSOR = 0;
    ov_en = 1'b1; ov_r = '0; ov_b = '0; ov_g = '0;
    repeat (2) @(negedge CLOCK);

    // Reset held with PIXEN toggling
    DE_IN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLOCK);
      PIXEN = (k % 2 == 0);
    end
    @(negedge CLOCK);
    nRESET = 1'b1; PIXEN = 1'b0;
    chk("reset_outputs", 32'({R, G, B, DE, HSYNC, VSYNC, VRD, CHAR_CE}), 32'h0);
    chk("reset_va_vplane", 32'({VA, VPLANE}), 32'h0);
    pulse_no = 0; first_ce = 0; ce_cnt = 0;
    acc_r = '0; acc_g = '0; acc_b = '0;

    // Directed characters; each one's pixels are checked during the next
    for (int i = 0; i < NV; i++) begin
      MA = tbl[i].ma; RA = tbl[i].ra; DE_IN = tbl[i].de; HS_IN = tbl[i].hs;
      VS_IN = 1'b0; CURSOR = tbl[i].cur;
      ov_r = tbl[i].vr; ov_b = tbl[i].vb; ov_g = tbl[i].vg;
      vrd_cnt = 0;
      for (int k = 0; k < 8; k++) begin
        pulse(1 + (k % 2));
        acc_r = {acc_r[6:0], smp_r};
        acc_g = {acc_g[6:0], smp_g};
        acc_b = {acc_b[6:0], smp_b};
        if (k == 6 && i > 0) begin
          chk($sformatf("tbl%0d_r", i - 1), 32'(acc_r), 32'(tbl[i-1].e_r));
          chk($sformatf("tbl%0d_b", i - 1), 32'(acc_b), 32'(tbl[i-1].e_b));
          chk($sformatf("tbl%0d_g", i - 1), 32'(acc_g), 32'(tbl[i-1].e_g));
          chk($sformatf("tbl%0d_de", i - 1), 32'(smp_de), 32'(tbl[i-1].e_de));
          chk($sformatf("tbl%0d_hs", i - 1), 32'(smp_hs), 32'(tbl[i-1].e_hs));
        end
      end
      chk($sformatf("tbl%0d_nvrd", i), 32'(vrd_cnt), 32'(tbl[i].e_nvrd));
      if (tbl[i].e_nvrd == 3) begin
        chk($sformatf("tbl%0d_va", i), 32'(va_seen), 32'(tbl[i].e_va));
        chk($sformatf("tbl%0d_planes", i), 32'({pl_seen[0], pl_seen[1], pl_seen[2]}), 32'(6'b00_01_10));
      end
      if (i == 0) chk("first_charce_pixen", 32'(first_ce), 32'd8);
    end

    // Stall: no PIXEN for 20 clocks
    vrd_cnt = 0; ce_cnt = 0;
    repeat (20) begin
      @(negedge CLOCK);
      observe();
    end
    chk("stall_vrd", 32'(vrd_cnt), 32'd0);
    chk("stall_charce", 32'(ce_cnt), 32'd0);

    // Reset in the middle of a fetch
    ov_en = 1'b0; DE_IN = 1'b1;
    repeat (10) pulse(1);
    @(negedge CLOCK); nRESET = 1'b0;
    repeat (2) @(negedge CLOCK);
    nRESET = 1'b1;
    vrd_cnt = 0;
    repeat (3) begin
      @(negedge CLOCK);
      observe();
    end
    chk("post_reset_no_vrd", 32'(vrd_cnt), 32'd0);

    // Randomized run against the model
    for (int p = 0; p < 2000; p++) begin
      MA     = 14'($urandom);
      RA     = 5'($urandom);
      DE_IN  = ($urandom_range(0, 3) != 0);
      HS_IN  = ($urandom_range(0, 7) == 0);
      VS_IN  = ($urandom_range(0, 7) == 0);
      CURSOR = ($urandom_range(0, 7) == 0);
      pulse($urandom_range(1, 3));
      if ($urandom_range(0, 399) == 0) begin
        @(negedge CLOCK); nRESET = 1'b0;
        repeat (2) @(negedge CLOCK);
        nRESET = 1'b1;
      end
    end
    repeat (4) @(negedge CLOCK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
